// File: rtl/ff_mode_pkg.sv
// Shared mode encoding for the universal flip-flop bank.
package ff_mode_pkg;

  localparam int MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_D  = 2'b00,
    MODE_T  = 2'b01,
    MODE_JK = 2'b10,
    MODE_SR = 2'b11
  } ff_mode_t;

endpackage

// File: rtl/ff_next_state.sv
// Single-channel next-state logic: maps the current q, the two inputs and
// the channel mode onto the D-register input. Purely combinational.
module ff_next_state
  import ff_mode_pkg::*;
(
  input  logic     q,
  input  logic     a,
  input  logic     b,
  input  ff_mode_t mode,
  output logic     d,
  output logic     illegal
);

  // S=R=1 in SR mode is flagged and the channel holds.
  always_comb begin
    d       = q;
    illegal = 1'b0;
    case (mode)
      MODE_D:  d = a;
      MODE_T:  d = q ^ a;
      MODE_JK: d = (a & ~q) | (~b & q);
      MODE_SR: begin
        if (a & b) begin
          illegal = 1'b1;
          d       = q;
        end else begin
          d = a | (~b & q);
        end
      end
      default: d = q;
    endcase
  end

endmodule

// File: rtl/ff_bank_universal.sv
// Bank of WIDTH flip-flop channels, each selectable as D/T/JK/SR, built on
// plain D registers. Also keeps a sticky per-channel SR-illegal flag and a
// saturating count of enabled cycles in which any output changed.
module ff_bank_universal
  import ff_mode_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter int               CNT_W   = 16,
  parameter logic [WIDTH-1:0] RESET_Q = {WIDTH{1'b0}}
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 cfg_we,
  input  logic [2*WIDTH-1:0]   cfg_mode,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 err_clr,
  input  logic                 cnt_clr,
  output logic [WIDTH-1:0]     q,
  output logic [2*WIDTH-1:0]   mode_q,
  output logic [WIDTH-1:0]     sr_err,
  output logic [CNT_W-1:0]     act_cnt
);

  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] illegal;
  logic [WIDTH-1:0] err_set;
  logic             any_change;
  logic             cnt_sat;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    ff_next_state u_ns (
      .q       (q[i]),
      .a       (in_a[i]),
      .b       (in_b[i]),
      .mode    (ff_mode_t'(mode_q[2*i +: 2])),
      .d       (d[i]),
      .illegal (illegal[i])
    );
  end

  // Error flags and counter only react to enabled cycles.
  assign err_set    = en ? illegal : '0;
  assign any_change = en && (d != q);
  assign cnt_sat    = (act_cnt == {CNT_W{1'b1}});

  // Channel outputs: load next state on enabled edges.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= RESET_Q;
    end else if (en) begin
      q <= d;
    end
  end

  // Mode register: independent of en; the q update above sees the old value.
  always_ff @(posedge clk) begin
    if (!rst) begin
      mode_q <= '0;
    end else if (cfg_we) begin
      mode_q <= cfg_mode;
    end
  end

  // Sticky illegal flags: a new set in the clearing cycle survives the clear.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sr_err <= '0;
    end else if (err_clr) begin
      sr_err <= err_set;
    end else begin
      sr_err <= sr_err | err_set;
    end
  end

  // Activity counter: clear beats increment, saturates instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      act_cnt <= '0;
    end else if (cnt_clr) begin
      act_cnt <= '0;
    end else if (any_change && !cnt_sat) begin
      act_cnt <= act_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_ff_bank_universal.sv
// Directed bench for ff_bank_universal. A second instance with a 2-bit
// counter shares all inputs and exercises counter saturation.
module tb_ff_bank_universal;

  logic        clk;
  logic        rst;
  logic        en;
  logic        cfg_we;
  logic [15:0] cfg_mode;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        err_clr;
  logic        cnt_clr;
  logic [7:0]  q;
  logic [15:0] mode_q;
  logic [7:0]  sr_err;
  logic [15:0] act_cnt;
  logic [7:0]  q2;
  logic [15:0] mode_q2;
  logic [7:0]  sr_err2;
  logic [1:0]  act_cnt2;

  int checks = 0;
  int errors = 0;

  ff_bank_universal #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .in_a(in_a), .in_b(in_b), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .q(q), .mode_q(mode_q), .sr_err(sr_err), .act_cnt(act_cnt)
  );

  ff_bank_universal #(.WIDTH(8), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .en(en), .cfg_we(cfg_we), .cfg_mode(cfg_mode),
    .in_a(in_a), .in_b(in_b), .err_clr(err_clr), .cnt_clr(cnt_clr),
    .q(q2), .mode_q(mode_q2), .sr_err(sr_err2), .act_cnt(act_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 0; en = 0; cfg_we = 0; cfg_mode = '0; in_a = '0; in_b = '0;
    err_clr = 0; cnt_clr = 0;
    step(); step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q, 8'h00); end
    checks++; if (mode_q !== 16'h0000) begin errors++; $display("FAIL reset_mode got %h exp %h", mode_q, 16'h0000); end
    checks++; if (sr_err !== 8'h00) begin errors++; $display("FAIL reset_err got %h exp %h", sr_err, 8'h00); end
    checks++; if (act_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt got %0d exp %0d", act_cnt, 0); end
    rst = 1;
  endtask

  task automatic test_d_mode();
    en = 1; in_a = 8'hA5;
    step();
    checks++; if (q !== 8'hA5) begin errors++; $display("FAIL d_q got %h exp %h", q, 8'hA5); end
    checks++; if (mode_q !== 16'h0000) begin errors++; $display("FAIL d_mode got %h exp %h", mode_q, 16'h0000); end
    checks++; if (act_cnt !== 16'd1) begin errors++; $display("FAIL d_cnt got %0d exp %0d", act_cnt, 1); end
    in_a = 8'h00;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL d_q_zero got %h exp %h", q, 8'h00); end
    checks++; if (act_cnt !== 16'd2) begin errors++; $display("FAIL d_cnt2 got %0d exp %0d", act_cnt, 2); end
  endtask

  task automatic test_t_mode();
    logic [7:0] exp_q [4];
    exp_q[0] = 8'h0F; exp_q[1] = 8'h00; exp_q[2] = 8'h0F; exp_q[3] = 8'h00;
    en = 0; cfg_we = 1; cfg_mode = 16'h5555;
    step();
    cfg_we = 0;
    checks++; if (mode_q !== 16'h5555) begin errors++; $display("FAIL t_mode_reg got %h exp %h", mode_q, 16'h5555); end
    en = 1; in_a = 8'h0F;
    for (int i = 0; i < 4; i++) begin
      step();
      checks++; if (q !== exp_q[i]) begin errors++; $display("FAIL t_q[%0d] got %h exp %h", i, q, exp_q[i]); end
    end
    checks++; if (act_cnt !== 16'd6) begin errors++; $display("FAIL t_cnt got %0d exp %0d", act_cnt, 6); end
    checks++; if (act_cnt2 !== 2'd3) begin errors++; $display("FAIL t_cnt_sat got %0d exp %0d", act_cnt2, 3); end
  endtask

  task automatic test_jk();
    logic [1:0] jk    [5];
    logic       exp_q [5];
    jk[0] = 2'b10; jk[1] = 2'b01; jk[2] = 2'b11; jk[3] = 2'b11; jk[4] = 2'b00;
    exp_q[0] = 1; exp_q[1] = 0; exp_q[2] = 1; exp_q[3] = 0; exp_q[4] = 0;
    en = 0; cfg_we = 1; cfg_mode = 16'hAAAA; in_a = '0; in_b = '0;
    step();
    cfg_we = 0; en = 1;
    for (int i = 0; i < 5; i++) begin
      in_a = {7'b0, jk[i][1]};
      in_b = {7'b0, jk[i][0]};
      step();
      checks++; if (q !== {7'b0, exp_q[i]}) begin errors++; $display("FAIL jk_q[%0d] got %h exp %h", i, q, {7'b0, exp_q[i]}); end
    end
    checks++; if (act_cnt !== 16'd10) begin errors++; $display("FAIL jk_cnt got %0d exp %0d", act_cnt, 10); end
  endtask

  task automatic test_sr_illegal();
    en = 0; cfg_we = 1; cfg_mode = 16'hFFFF; in_a = '0; in_b = '0;
    step();
    cfg_we = 0; en = 1;
    in_a = 8'h08; in_b = 8'h00;
    step();
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL sr_set got %h exp %h", q, 8'h08); end
    in_a = 8'h08; in_b = 8'h08;
    step();
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL sr_ill_hold got %h exp %h", q, 8'h08); end
    checks++; if (sr_err !== 8'h08) begin errors++; $display("FAIL sr_err_set got %h exp %h", sr_err, 8'h08); end
    in_a = 8'h00; in_b = 8'h00;
    step();
    checks++; if (sr_err !== 8'h08) begin errors++; $display("FAIL sr_err_sticky got %h exp %h", sr_err, 8'h08); end
    in_a = 8'h0A; in_b = 8'h0A;
    step();
    checks++; if (sr_err !== 8'h0A) begin errors++; $display("FAIL sr_err_two got %h exp %h", sr_err, 8'h0A); end
    checks++; if (q !== 8'h08) begin errors++; $display("FAIL sr_two_hold got %h exp %h", q, 8'h08); end
    err_clr = 1; in_a = 8'h08; in_b = 8'h08;
    step();
    checks++; if (sr_err !== 8'h08) begin errors++; $display("FAIL sr_clr_vs_set got %h exp %h", sr_err, 8'h08); end
    in_a = 8'h00; in_b = 8'h00;
    step();
    err_clr = 0;
    checks++; if (sr_err !== 8'h00) begin errors++; $display("FAIL sr_clr got %h exp %h", sr_err, 8'h00); end
    en = 0; in_a = 8'h10; in_b = 8'h10;
    step();
    checks++; if (sr_err !== 8'h00) begin errors++; $display("FAIL sr_dis_noset got %h exp %h", sr_err, 8'h00); end
    checks++; if (act_cnt !== 16'd11) begin errors++; $display("FAIL sr_cnt got %0d exp %0d", act_cnt, 11); end
  endtask

  task automatic test_mode_switch();
    en = 0; cfg_we = 1; cfg_mode = 16'h0000; in_a = '0; in_b = '0;
    step();
    cfg_we = 0; en = 1; in_a = 8'h00;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL sw_clear got %h exp %h", q, 8'h00); end
    cfg_we = 1; cfg_mode = 16'h5555; in_a = 8'h01;
    step();
    cfg_we = 0;
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL sw_old_mode got %h exp %h", q, 8'h01); end
    checks++; if (mode_q !== 16'h5555) begin errors++; $display("FAIL sw_mode_reg got %h exp %h", mode_q, 16'h5555); end
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL sw_new_mode got %h exp %h", q, 8'h00); end
    checks++; if (act_cnt !== 16'd14) begin errors++; $display("FAIL sw_cnt got %0d exp %0d", act_cnt, 14); end
  endtask

  task automatic test_enable_and_counter();
    logic [7:0] pat [3];
    pat[0] = 8'hFF; pat[1] = 8'h0F; pat[2] = 8'hF0;
    en = 0;
    for (int i = 0; i < 3; i++) begin
      in_a = pat[i]; in_b = ~pat[i];
      step();
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL en_q_frozen got %h exp %h", q, 8'h00); end
    checks++; if (act_cnt !== 16'd14) begin errors++; $display("FAIL en_cnt_frozen got %0d exp %0d", act_cnt, 14); end
    en = 1; in_a = 8'h01; in_b = 8'h00; cnt_clr = 1;
    step();
    cnt_clr = 0;
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL clr_q got %h exp %h", q, 8'h01); end
    checks++; if (act_cnt !== 16'd0) begin errors++; $display("FAIL clr_wins got %0d exp %0d", act_cnt, 0); end
    checks++; if (act_cnt2 !== 2'd0) begin errors++; $display("FAIL clr_wins_sat got %0d exp %0d", act_cnt2, 0); end
    in_a = 8'hFF;
    for (int i = 0; i < 5; i++) step();
    checks++; if (q !== 8'hFE) begin errors++; $display("FAIL sat_q got %h exp %h", q, 8'hFE); end
    checks++; if (act_cnt !== 16'd5) begin errors++; $display("FAIL sat_cnt16 got %0d exp %0d", act_cnt, 5); end
    checks++; if (act_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_cnt2 got %0d exp %0d", act_cnt2, 3); end
  endtask

  task automatic test_reset_mid();
    en = 0; cfg_we = 1; cfg_mode = 16'hFFFF;
    step();
    cfg_we = 0; en = 1; in_a = 8'hFF; in_b = 8'hFF;
    step();
    checks++; if (sr_err !== 8'hFF) begin errors++; $display("FAIL mid_pre_err got %h exp %h", sr_err, 8'hFF); end
    rst = 0; cfg_we = 1; cfg_mode = 16'h5555; in_a = 8'h3C; in_b = 8'h00;
    step();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL mid_q got %h exp %h", q, 8'h00); end
    checks++; if (mode_q !== 16'h0000) begin errors++; $display("FAIL mid_mode got %h exp %h", mode_q, 16'h0000); end
    checks++; if (sr_err !== 8'h00) begin errors++; $display("FAIL mid_err got %h exp %h", sr_err, 8'h00); end
    checks++; if (act_cnt !== 16'd0) begin errors++; $display("FAIL mid_cnt got %0d exp %0d", act_cnt, 0); end
    checks++; if (act_cnt2 !== 2'd0) begin errors++; $display("FAIL mid_cnt_sat got %0d exp %0d", act_cnt2, 0); end
    rst = 1; cfg_we = 0; en = 0;
  endtask

  initial begin
    test_reset();
    test_d_mode();
    test_t_mode();
    test_jk();
    test_sr_illegal();
    test_mode_switch();
    test_enable_and_counter();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ff_bank_universal.md
Name: ff_bank_universal

Overview:
- Parametrised bank of WIDTH independent single-bit flip-flop channels. Each channel runs in D, T, JK or SR mode, selected per channel from a mode register.
- Next state in every mode is derived through D-register logic: one D register per channel plus next-state logic.
- Adds a clock enable, a per-channel sticky SR-illegal flag and a saturating activity counter.
- Sits in the flip-flop conversion library as the general-purpose successor to the fixed single-mode converters.

Parameters:
WIDTH, 8, number of flip-flop channels (>=1)
CNT_W, 16, width of activity counter (>=2)
RESET_Q, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (rst==0 at a rising clk edge resets)
en  in  1  clock enable for q update, error flags and counter increment
cfg_we  in  1  load mode register from cfg_mode
cfg_mode  in  2*WIDTH  per-channel mode; bits [2i+1:2i] belong to channel i
in_a  in  WIDTH  D / T / J / S input, per channel
in_b  in  WIDTH  K / R input, per channel; ignored in D and T modes
err_clr  in  1  clear all sr_err bits
cnt_clr  in  1  clear activity counter
q  out  WIDTH  flip-flop outputs
mode_q  out  2*WIDTH  current mode register
sr_err  out  WIDTH  sticky: channel saw S=R=1 while enabled in SR mode
act_cnt  out  CNT_W  saturating count of enabled cycles in which any q bit changed

Behaviour:
- Mode encoding: 2'b00 D, 2'b01 T, 2'b10 JK, 2'b11 SR.
- Reset (rst==0 at edge; overrides all other inputs):
  - q = RESET_Q
  - mode_q = all 2'b00 (D)
  - sr_err = 0
  - act_cnt = 0
- Next-state per channel i, with a=in_a[i], b=in_b[i], m=mode_q[2i+1:2i]:
  - D: d = a
  - T: d = q ^ a
  - JK: d = (a & ~q) | (~b & q)
  - SR: d = a | (~b & q) when !(a & b); d = q (hold) when a=b=1
- Update and latency:
  - en=1: q <= d at the edge; one-cycle latency from inputs to q.
  - en=0: q holds; sr_err not set; act_cnt not incremented.
- Mode register:
  - cfg_we=1: mode_q <= cfg_mode at the edge, regardless of en.
  - The q update in that same edge uses the OLD mode_q; the new mode applies from the next edge.
- SR illegal:
  - mode SR, en=1, a=b=1 → sr_err[i] <= 1 and q[i] holds.
  - Bits are sticky until err_clr.
  - err_clr and a new set in the same cycle: set wins (bit ends 1). Other bits clear.
- Activity counter:
  - Increments when en=1 and d != q (any bit).
  - Saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr=1 forces 0 even if an increment occurs the same cycle (clear wins).
- Reset asserted mid-operation: all state returns to reset values on that edge; inputs that cycle are ignored.
- No combinational path from inputs to outputs; all outputs are registers.

Decomposition:
- Package ff_mode_pkg:
  - Mode constants MODE_D, MODE_T, MODE_JK, MODE_SR (2-bit)
  - Typedef ff_mode_t
- Sub-module ff_next_state: purely combinational single channel (q, a, b, mode → d, illegal). Instantiated WIDTH times via generate.
- Top level holds all registers, the error logic and the counter.

Test Plan:
- Reset/D mode: rst=0 for 2 cycles, then WIDTH=8, en=1, in_a=8'hA5 → q=8'hA5 one cycle later. mode_q=0, act_cnt=1.
- T mode toggling: cfg_mode all 2'b01, in_a=8'h0F held 4 enabled cycles from q=0 → q: 0F,00,0F,00. act_cnt increments by 4.
- JK truth table on channel 0: J/K = 10,01,11,11,00 → q0 = 1,0,1,0,0 (hold on 00).
- SR illegal on channel 3: S=R=1 with q3=1 → q3 stays 1, sr_err=8'h08 persists. err_clr with S=R=1 same cycle → remains 08. err_clr alone → 00.
- Mode switch timing: in D mode with in_a=1, assert cfg_we→T and in_a=1 in the same cycle → that edge behaves as D (q=1). Next edge toggles (q=0).
- Enable/saturation/reset: en=0 with toggling inputs → q and act_cnt frozen. CNT_W=2 with 5 changing cycles → act_cnt=3. rst=0 mid-run → all outputs reset next edge.
